// File: rtl/pipeline_processor_param.sv
// pipeline_processor_param: parametrised 3-stage in-order integer pipeline
// ACCEPT -> EX -> WB with valid/ready, WB->EX bypass, flush, retire count
module pipeline_processor_param #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 8,
  parameter int IMM_W    = 12,
  localparam int REG_AW  = $clog2(NUM_REGS),
  localparam int INSTR_W = 4 + 3 * REG_AW + IMM_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [DATA_W-1:0]  result,
  output logic [REG_AW-1:0]  result_rd,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [31:0]        retire_count,
  output logic               illegal_err
);

  localparam int SH_W = $clog2(DATA_W);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_ADDI = 4'd7,
    OP_SLT  = 4'd8,
    OP_NOP  = 4'd9
  } op_e;

  logic               ex_valid_q, ex_valid_d;
  logic [INSTR_W-1:0] ex_instr_q, ex_instr_d;
  logic               wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0]  wb_result_q, wb_result_d;
  logic [REG_AW-1:0]  wb_rd_q, wb_rd_d;
  logic               wb_we_q, wb_we_d;
  logic               wb_ill_q, wb_ill_d;
  logic [31:0]        retire_q, retire_d;
  logic               illegal_q, illegal_d;
  logic [DATA_W-1:0]  regs_q [NUM_REGS];

  logic [3:0]         ex_op;
  logic [REG_AW-1:0]  ex_rd;
  logic [REG_AW-1:0]  ex_rs1;
  logic [REG_AW-1:0]  ex_rs2;
  logic [IMM_W-1:0]   ex_imm;
  logic signed [IMM_W-1:0] imm_s;
  logic [DATA_W-1:0]  imm_sx;
  logic [DATA_W-1:0]  op_a;
  logic [DATA_W-1:0]  op_b;
  logic [DATA_W-1:0]  alu_res;
  logic               alu_we;
  logic               alu_ill;
  logic               fwd_ok;
  logic               advance;
  logic               accept;
  logic               retire;

  assign ex_op  = ex_instr_q[INSTR_W-1 -: 4];
  assign ex_rd  = ex_instr_q[INSTR_W-5 -: REG_AW];
  assign ex_rs1 = ex_instr_q[INSTR_W-5-REG_AW -: REG_AW];
  assign ex_rs2 = ex_instr_q[IMM_W+REG_AW-1 -: REG_AW];
  assign ex_imm = ex_instr_q[IMM_W-1:0];
  assign imm_s  = ex_imm;
  assign imm_sx = DATA_W'(imm_s);

  // A stalled WB blocks the whole pipe; flush also refuses new work
  assign advance     = !wb_valid_q || result_ready;
  assign instr_ready = advance && !flush;
  assign accept      = instr_valid && instr_ready;
  assign retire      = wb_valid_q && result_ready && !flush;

  assign result       = wb_result_q;
  assign result_rd    = wb_rd_q;
  assign result_valid = wb_valid_q;
  assign retire_count = retire_q;
  assign illegal_err  = illegal_q;

  assign fwd_ok = wb_valid_q && wb_we_q;

  // Operand fetch: r0 is hardwired, WB result bypasses the regfile
  always_comb begin
    op_a = '0;
    op_b = '0;
    if (ex_rs1 != '0) op_a = regs_q[ex_rs1];
    if (ex_rs2 != '0) op_b = regs_q[ex_rs2];
    if (fwd_ok && ex_rs1 != '0 && wb_rd_q == ex_rs1) op_a = wb_result_q;
    if (fwd_ok && ex_rs2 != '0 && wb_rd_q == ex_rs2) op_b = wb_result_q;
  end

  // Execute: opcodes 10-15 behave as NOP but are flagged
  always_comb begin
    alu_res = '0;
    alu_we  = 1'b1;
    alu_ill = 1'b0;
    case (ex_op)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SLL:  alu_res = op_a << op_b[SH_W-1:0];
      OP_SRL:  alu_res = op_a >> op_b[SH_W-1:0];
      OP_ADDI: alu_res = op_a + imm_sx;
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}},
                          $signed(op_a) < $signed(op_b)};
      OP_NOP:  alu_we  = 1'b0;
      default: begin
        alu_we  = 1'b0;
        alu_ill = 1'b1;
      end
    endcase
  end

  // Next state of both stages, retire counter and sticky error
  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_instr_d  = ex_instr_q;
    wb_valid_d  = wb_valid_q;
    wb_result_d = wb_result_q;
    wb_rd_d     = wb_rd_q;
    wb_we_d     = wb_we_q;
    wb_ill_d    = wb_ill_q;
    retire_d    = retire_q;
    illegal_d   = illegal_q;
    if (flush) begin
      ex_valid_d = 1'b0;
      wb_valid_d = 1'b0;
    end else if (advance) begin
      ex_valid_d = accept;
      if (accept) ex_instr_d = instr;
      wb_valid_d = ex_valid_q;
      if (ex_valid_q) begin
        wb_result_d = alu_res;
        wb_rd_d     = ex_rd;
        wb_we_d     = alu_we;
        wb_ill_d    = alu_ill;
      end
    end
    if (retire) begin
      retire_d = retire_q + 32'd1;
      if (wb_ill_q) illegal_d = 1'b1;
    end
  end

  // Pipeline and status registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q  <= 1'b0;
      ex_instr_q  <= '0;
      wb_valid_q  <= 1'b0;
      wb_result_q <= '0;
      wb_rd_q     <= '0;
      wb_we_q     <= 1'b0;
      wb_ill_q    <= 1'b0;
      retire_q    <= '0;
      illegal_q   <= 1'b0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_instr_q  <= ex_instr_d;
      wb_valid_q  <= wb_valid_d;
      wb_result_q <= wb_result_d;
      wb_rd_q     <= wb_rd_d;
      wb_we_q     <= wb_we_d;
      wb_ill_q    <= wb_ill_d;
      retire_q    <= retire_d;
      illegal_q   <= illegal_d;
    end
  end

  // Register file write on retirement; r0 writes are dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (retire && wb_we_q && wb_rd_q != '0) begin
      regs_q[wb_rd_q] <= wb_result_q;
    end
  end

endmodule

// File: tb/tb_pipeline_processor_param.sv
// tb_pipeline_processor_param: directed checks of the 3-stage pipeline
// default config DATA_W=32, NUM_REGS=8, IMM_W=12
module tb_pipeline_processor_param;

  localparam int IW = 25;

  logic          clk;
  logic          reset;
  logic          flush;
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   result;
  logic [2:0]    result_rd;
  logic          result_valid;
  logic          result_ready;
  logic [31:0]   retire_count;
  logic          illegal_err;

  int checks;
  int failures;
  int exp_retire;

  pipeline_processor_param dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .result       (result),
    .result_rd    (result_rd),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .retire_count (retire_count),
    .illegal_err  (illegal_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [IW-1:0] enc(input logic [3:0] op,
                                        input logic [2:0] rd,
                                        input logic [2:0] rs1,
                                        input logic [2:0] rs2,
                                        input logic [11:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [IW-1:0] w);
    instr       = w;
    instr_valid = 1'b1;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    flush        = 1'b0;
    instr        = '0;
    instr_valid  = 1'b0;
    result_ready = 1'b1;
    #2;
    checks++;
    if (result_valid !== 1'b0 || retire_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_async: valid=%b cnt=%0d want 0/0",
               result_valid, retire_count);
    end
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({instr_ready, result_valid, illegal_err} !== 3'b100) begin
      failures++;
      $display("FAIL reset_release: rdy/val/ill=%b want 100",
               {instr_ready, result_valid, illegal_err});
    end
    exp_retire = 0;
  endtask

  task automatic test_alu();
    logic [IW-1:0] prog [11];
    logic [31:0]   expv [11];
    logic [2:0]    exrd [11];
    int            base;
    prog[0]  = enc(4'd7, 3'd1, 3'd0, 3'd0, 12'd5);
    prog[1]  = enc(4'd7, 3'd2, 3'd0, 3'd0, 12'd7);
    prog[2]  = enc(4'd0, 3'd3, 3'd1, 3'd2, 12'd0);
    prog[3]  = enc(4'd1, 3'd4, 3'd1, 3'd2, 12'd0);
    prog[4]  = enc(4'd8, 3'd5, 3'd4, 3'd1, 12'd0);
    prog[5]  = enc(4'd5, 3'd6, 3'd1, 3'd2, 12'd0);
    prog[6]  = enc(4'd7, 3'd7, 3'd0, 3'd0, 12'hFFF);
    prog[7]  = enc(4'd6, 3'd4, 3'd7, 3'd2, 12'd0);
    prog[8]  = enc(4'd4, 3'd5, 3'd7, 3'd1, 12'd0);
    prog[9]  = enc(4'd3, 3'd6, 3'd6, 3'd3, 12'd0);
    prog[10] = enc(4'd2, 3'd2, 3'd7, 3'd6, 12'd0);
    expv[0]  = 32'd5;        exrd[0]  = 3'd1;
    expv[1]  = 32'd7;        exrd[1]  = 3'd2;
    expv[2]  = 32'd12;       exrd[2]  = 3'd3;
    expv[3]  = 32'hFFFFFFFE; exrd[3]  = 3'd4;
    expv[4]  = 32'd1;        exrd[4]  = 3'd5;
    expv[5]  = 32'd640;      exrd[5]  = 3'd6;
    expv[6]  = 32'hFFFFFFFF; exrd[6]  = 3'd7;
    expv[7]  = 32'h01FFFFFF; exrd[7]  = 3'd4;
    expv[8]  = 32'hFFFFFFFA; exrd[8]  = 3'd5;
    expv[9]  = 32'd652;      exrd[9]  = 3'd6;
    expv[10] = 32'd652;      exrd[10] = 3'd2;
    base = exp_retire;
    for (int i = 0; i <= 11; i++) begin
      if (i < 11) put(prog[i]);
      else instr_valid = 1'b0;
      tick();
      if (i > 0) begin
        checks++;
        if ({result_valid, result, result_rd} !==
            {1'b1, expv[i-1], exrd[i-1]}) begin
          failures++;
          $display("FAIL alu[%0d]: v=%b res=%h rd=%0d want res=%h rd=%0d",
                   i - 1, result_valid, result, result_rd,
                   expv[i-1], exrd[i-1]);
        end
        checks++;
        if (retire_count !== 32'(base + i - 1)) begin
          failures++;
          $display("FAIL alu_cnt[%0d]: cnt=%0d want %0d",
                   i - 1, retire_count, base + i - 1);
        end
      end
    end
    tick();
    exp_retire = base + 11;
    checks++;
    if (result_valid !== 1'b0 || retire_count !== 32'(exp_retire)) begin
      failures++;
      $display("FAIL alu_drain: v=%b cnt=%0d want 0/%0d",
               result_valid, retire_count, exp_retire);
    end
  endtask

  task automatic test_backpressure();
    result_ready = 1'b0;
    put(enc(4'd7, 3'd1, 3'd0, 3'd0, 12'd1));
    #1;
    checks++;
    if (instr_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_ready_empty: rdy=%b want 1", instr_ready);
    end
    tick();
    put(enc(4'd7, 3'd2, 3'd0, 3'd0, 12'd2));
    tick();
    checks++;
    if ({instr_ready, result_valid, result, result_rd} !==
        {1'b0, 1'b1, 32'd1, 3'd1}) begin
      failures++;
      $display("FAIL bp_fill: rdy=%b v=%b res=%h rd=%0d want 0/1/1/1",
               instr_ready, result_valid, result, result_rd);
    end
    put(enc(4'd7, 3'd3, 3'd0, 3'd0, 12'd3));
    tick();
    checks++;
    if ({instr_ready, result_valid, result, result_rd} !==
        {1'b0, 1'b1, 32'd1, 3'd1} ||
        retire_count !== 32'(exp_retire)) begin
      failures++;
      $display("FAIL bp_hold: rdy=%b res=%h rd=%0d cnt=%0d want 0/1/1/%0d",
               instr_ready, result, result_rd, retire_count, exp_retire);
    end
    result_ready = 1'b1;
    tick();
    instr_valid = 1'b0;
    checks++;
    if ({result_valid, result, result_rd} !== {1'b1, 32'd2, 3'd2} ||
        retire_count !== 32'(exp_retire + 1)) begin
      failures++;
      $display("FAIL bp_r2: v=%b res=%h rd=%0d cnt=%0d want 2/2/%0d",
               result_valid, result, result_rd, retire_count,
               exp_retire + 1);
    end
    tick();
    checks++;
    if ({result_valid, result, result_rd} !== {1'b1, 32'd3, 3'd3}) begin
      failures++;
      $display("FAIL bp_r3: v=%b res=%h rd=%0d want 3/3",
               result_valid, result, result_rd);
    end
    tick();
    exp_retire += 3;
    checks++;
    if (result_valid !== 1'b0 || retire_count !== 32'(exp_retire)) begin
      failures++;
      $display("FAIL bp_drain: v=%b cnt=%0d want 0/%0d",
               result_valid, retire_count, exp_retire);
    end
  endtask

  task automatic test_r0();
    put(enc(4'd7, 3'd0, 3'd0, 3'd0, 12'd9));
    tick();
    put(enc(4'd0, 3'd1, 3'd0, 3'd0, 12'd0));
    tick();
    checks++;
    if ({result_valid, result, result_rd} !== {1'b1, 32'd9, 3'd0}) begin
      failures++;
      $display("FAIL r0_out: v=%b res=%h rd=%0d want 9/0",
               result_valid, result, result_rd);
    end
    put(enc(4'd0, 3'd6, 3'd1, 3'd0, 12'd0));
    tick();
    instr_valid = 1'b0;
    checks++;
    if ({result_valid, result, result_rd} !== {1'b1, 32'd0, 3'd1}) begin
      failures++;
      $display("FAIL r0_nofwd: v=%b res=%h rd=%0d want 0/1",
               result_valid, result, result_rd);
    end
    tick();
    checks++;
    if ({result_valid, result, result_rd} !== {1'b1, 32'd0, 3'd6}) begin
      failures++;
      $display("FAIL r1_zero: v=%b res=%h rd=%0d want 0/6",
               result_valid, result, result_rd);
    end
    tick();
    exp_retire += 3;
  endtask

  task automatic test_illegal_flush();
    logic [2:0]  rr [3];
    logic [31:0] ev [3];
    put(enc(4'hF, 3'd3, 3'd1, 3'd2, 12'd0));
    tick();
    instr_valid = 1'b0;
    tick();
    checks++;
    if ({result_valid, result, illegal_err} !== {1'b1, 32'd0, 1'b0}) begin
      failures++;
      $display("FAIL ill_wb: v=%b res=%h ill=%b want 1/0/0",
               result_valid, result, illegal_err);
    end
    tick();
    exp_retire += 1;
    checks++;
    if (illegal_err !== 1'b1 || retire_count !== 32'(exp_retire)) begin
      failures++;
      $display("FAIL ill_set: ill=%b cnt=%0d want 1/%0d",
               illegal_err, retire_count, exp_retire);
    end
    put(enc(4'd7, 3'd1, 3'd0, 3'd0, 12'h055));
    tick();
    put(enc(4'd7, 3'd2, 3'd0, 3'd0, 12'h066));
    tick();
    flush = 1'b1;
    put(enc(4'd7, 3'd3, 3'd0, 3'd0, 12'h077));
    #1;
    checks++;
    if (instr_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_ready: rdy=%b want 0", instr_ready);
    end
    tick();
    flush = 1'b0;
    instr_valid = 1'b0;
    checks++;
    if (result_valid !== 1'b0 || retire_count !== 32'(exp_retire)) begin
      failures++;
      $display("FAIL flush_drop: v=%b cnt=%0d want 0/%0d",
               result_valid, retire_count, exp_retire);
    end
    tick();
    checks++;
    if (result_valid !== 1'b0 || illegal_err !== 1'b1) begin
      failures++;
      $display("FAIL flush_after: v=%b ill=%b want 0/1",
               result_valid, illegal_err);
    end
    rr[0] = 3'd1; ev[0] = 32'd0;
    rr[1] = 3'd2; ev[1] = 32'd2;
    rr[2] = 3'd3; ev[2] = 32'd3;
    for (int i = 0; i <= 3; i++) begin
      if (i < 3) put(enc(4'd0, rr[i], rr[i], 3'd0, 12'd0));
      else instr_valid = 1'b0;
      tick();
      if (i > 0) begin
        checks++;
        if ({result_valid, result, result_rd} !==
            {1'b1, ev[i-1], rr[i-1]}) begin
          failures++;
          $display("FAIL flush_reg r%0d: v=%b res=%h want %h",
                   rr[i-1], result_valid, result, ev[i-1]);
        end
      end
    end
    tick();
    exp_retire += 3;
    checks++;
    if (illegal_err !== 1'b1 || retire_count !== 32'(exp_retire)) begin
      failures++;
      $display("FAIL ill_sticky: ill=%b cnt=%0d want 1/%0d",
               illegal_err, retire_count, exp_retire);
    end
  endtask

  task automatic test_reset_mid();
    put(enc(4'd7, 3'd1, 3'd0, 3'd0, 12'd9));
    tick();
    put(enc(4'd7, 3'd2, 3'd0, 3'd0, 12'd8));
    tick();
    put(enc(4'd0, 3'd3, 3'd1, 3'd2, 12'd0));
    tick();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({result_valid, illegal_err} !== 2'b00 ||
        retire_count !== 32'd0) begin
      failures++;
      $display("FAIL rst_mid: v=%b ill=%b cnt=%0d want 0/0/0",
               result_valid, illegal_err, retire_count);
    end
    instr_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    exp_retire = 0;
    checks++;
    if (instr_ready !== 1'b1 || result_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_rel: rdy=%b v=%b want 1/0",
               instr_ready, result_valid);
    end
    for (int i = 1; i <= 8; i++) begin
      if (i <= 7) put(enc(4'd0, 3'(i), 3'(i), 3'd0, 12'd0));
      else instr_valid = 1'b0;
      tick();
      if (i > 1) begin
        checks++;
        if ({result_valid, result, result_rd} !==
            {1'b1, 32'd0, 3'(i - 1)}) begin
          failures++;
          $display("FAIL rst_reg r%0d: v=%b res=%h rd=%0d want 0",
                   i - 1, result_valid, result, result_rd);
        end
      end
    end
    tick();
    exp_retire = 7;
    checks++;
    if (retire_count !== 32'(exp_retire)) begin
      failures++;
      $display("FAIL rst_cnt: cnt=%0d want %0d", retire_count, exp_retire);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    exp_retire = 0;
    test_reset();
    test_alu();
    test_backpressure();
    test_r0();
    test_illegal_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
